// File: rtl/multi_divider.sv
// multi_divider: CH independent programmable clock dividers sharing one
// clock domain. Each channel counts 0..DIV and toggles its output on the
// terminal count, so the output period is 2*(DIV+1) cycles at 50% duty.
// Outputs are registered; there is no combinational path from inputs to
// CLK_OUT or TICK.
//
// Control strobes, all sampled on the rising edge of CLK_50M:
//   CLR  (async) > SYNC > LOAD > EN count > hold
// SYNC realigns every channel (count and output cleared, divide kept).
// LOAD rewrites one channel's divide value and restarts its count while
// leaving its output level alone; a LOAD_CH that names no channel is
// ignored. The block supports only 2**CHW >= CH.
module multi_divider #(
  parameter int N       = 26,
  parameter int CH      = 4,
  parameter int CHW     = 2,
  parameter int DEF_DIV = 24999999
) (
  input  logic           CLK_50M,
  input  logic           CLR,
  input  logic           EN,
  input  logic           SYNC,
  input  logic           LOAD,
  input  logic [CHW-1:0] LOAD_CH,
  input  logic [N-1:0]   DIV_IN,
  output logic [CH-1:0]  CLK_OUT,
  output logic [CH-1:0]  TICK
);

  localparam logic [N-1:0] DEF_DIV_V = N'(DEF_DIV);

  logic [N-1:0]  div_q [CH];
  logic [N-1:0]  cnt_q [CH];
  logic [CH-1:0] load_hit;

  // Decode which channel (if any) the LOAD strobe targets this cycle.
  always_comb begin
    load_hit = '0;
    for (int ch = 0; ch < CH; ch++) begin
      load_hit[ch] = LOAD && (LOAD_CH == CHW'(ch));
    end
  end

  // Per-channel divide/count state and registered outputs.
  always_ff @(posedge CLK_50M or posedge CLR) begin
    if (CLR) begin
      for (int ch = 0; ch < CH; ch++) begin
        div_q[ch]   <= DEF_DIV_V;
        cnt_q[ch]   <= '0;
        CLK_OUT[ch] <= 1'b0;
        TICK[ch]    <= 1'b0;
      end
    end else if (SYNC) begin
      // Realign all channels; any simultaneous LOAD is dropped.
      for (int ch = 0; ch < CH; ch++) begin
        cnt_q[ch]   <= '0;
        CLK_OUT[ch] <= 1'b0;
        TICK[ch]    <= 1'b0;
      end
    end else begin
      for (int ch = 0; ch < CH; ch++) begin
        if (load_hit[ch]) begin
          // New divide value; output level is kept so no glitch on reload.
          div_q[ch] <= DIV_IN;
          cnt_q[ch] <= '0;
          TICK[ch]  <= 1'b0;
        end else if (EN) begin
          // >= rather than == so a count above DIV wraps on the next cycle
          // and a full-scale DIV never needs the counter to overflow.
          if (cnt_q[ch] >= div_q[ch]) begin
            cnt_q[ch]   <= '0;
            CLK_OUT[ch] <= ~CLK_OUT[ch];
            TICK[ch]    <= 1'b1;
          end else begin
            cnt_q[ch] <= cnt_q[ch] + 1'b1;
            TICK[ch]  <= 1'b0;
          end
        end else begin
          TICK[ch] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_divider.sv
// Testbench for multi_divider (N=8, CH=4, CHW=2, DEF_DIV=5).
// The reference model tracks, per channel, the number of enabled cycles
// since the last restart and the output level at that restart; the output
// level and tick follow from integer division by (DIV+1).
module tb_multi_divider;

  localparam int N       = 8;
  localparam int CH      = 4;
  localparam int CHW     = 2;
  localparam int DEF_DIV = 5;

  logic           clk;
  logic           clr;
  logic           en;
  logic           sync;
  logic           load;
  logic [CHW-1:0] load_ch;
  logic [N-1:0]   div_in;
  logic [CH-1:0]  clk_out;
  logic [CH-1:0]  tick;

  int checks;
  int errors;

  // reference model state
  int   m_div  [CH];
  int   m_e    [CH];
  logic m_lvl  [CH];
  logic m_clk  [CH];
  logic m_tick [CH];

  multi_divider #(
    .N(N), .CH(CH), .CHW(CHW), .DEF_DIV(DEF_DIV)
  ) dut (
    .CLK_50M (clk),
    .CLR     (clr),
    .EN      (en),
    .SYNC    (sync),
    .LOAD    (load),
    .LOAD_CH (load_ch),
    .DIV_IN  (div_in),
    .CLK_OUT (clk_out),
    .TICK    (tick)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_div[c]  = DEF_DIV;
      m_e[c]    = 0;
      m_lvl[c]  = 1'b0;
      m_clk[c]  = 1'b0;
      m_tick[c] = 1'b0;
    end
  endfunction

  // One rising edge of the reference model, from the current inputs.
  function automatic void model_clock();
    for (int c = 0; c < CH; c++) begin
      if (sync) begin
        m_e[c]    = 0;
        m_lvl[c]  = 1'b0;
        m_clk[c]  = 1'b0;
        m_tick[c] = 1'b0;
      end else if (load && int'(load_ch) == c) begin
        m_div[c]  = int'(div_in);
        m_e[c]    = 0;
        m_lvl[c]  = m_clk[c];
        m_tick[c] = 1'b0;
      end else if (en) begin
        m_e[c]    = m_e[c] + 1;
        m_tick[c] = (m_e[c] % (m_div[c] + 1)) == 0;
        m_clk[c]  = m_lvl[c] ^ logic'((m_e[c] / (m_div[c] + 1)) % 2);
      end else begin
        m_tick[c] = 1'b0;
      end
    end
  endfunction

  function automatic logic [CH-1:0] exp_clk();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = m_clk[c];
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_tick();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = m_tick[c];
    return v;
  endfunction

  task automatic check_outputs(input string tag);
    logic [CH-1:0] ec;
    logic [CH-1:0] et;
    ec = exp_clk();
    et = exp_tick();
    checks++;
    assert (clk_out === ec) else begin
      errors++;
      $error("FAIL %s clk_out observed=%b expected=%b t=%0t", tag, clk_out, ec, $time);
    end
    checks++;
    assert (tick === et) else begin
      errors++;
      $error("FAIL %s tick observed=%b expected=%b t=%0t", tag, tick, et, $time);
    end
  endtask

  // driver: advance one clock with the inputs currently applied, then check
  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    check_outputs(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_load(input int ch, input int d, input string tag);
    load    = 1'b1;
    load_ch = CHW'(ch);
    div_in  = N'(d);
    step(tag);
    load    = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clr     = 1'b1;
    en      = 1'b0;
    sync    = 1'b0;
    load    = 1'b0;
    load_ch = '0;
    div_in  = '0;
    model_reset();

    // reset state
    #12;
    check_outputs("reset");
    clr = 1'b0;

    // first toggle on the (DEF_DIV+1)th edge
    en = 1'b1;
    run(14, "def_div");

    // load and basic division: ch0 DIV=3
    do_load(0, 3, "load_ch0");
    run(20, "div3");

    // edge divide values: ch1 DIV=0, ch2 DIV=255
    do_load(1, 0, "load_ch1");
    do_load(2, 255, "load_ch2");
    run(530, "edge_div");

    // runtime reload: ch0 DIV=9, run to CNT=7, reload DIV=2
    do_load(0, 9, "load9");
    run(7, "pre_reload");
    do_load(0, 2, "reload2");
    run(8, "post_reload");

    // enable gating for 5 cycles mid-period
    run(2, "pre_gate");
    en = 1'b0;
    run(5, "gated");
    en = 1'b1;
    run(12, "post_gate");

    // SYNC with simultaneous LOAD to ch3: load must be discarded
    sync    = 1'b1;
    load    = 1'b1;
    load_ch = 2'd3;
    div_in  = 8'd1;
    step("sync_load");
    sync = 1'b0;
    load = 1'b0;
    run(14, "post_sync");

    // equal DIV on ch0/ch1, then SYNC, then compare over time
    do_load(0, 4, "eq0");
    do_load(1, 4, "eq1");
    run(3, "eq_skew");
    sync = 1'b1;
    step("eq_sync");
    sync = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step("eq_run");
      checks++;
      assert (clk_out[0] === clk_out[1] && tick[0] === tick[1]) else begin
        errors++;
        $error("FAIL aligned ch0=%b/%b ch1=%b/%b", clk_out[0], tick[0], clk_out[1], tick[1]);
      end
    end

    // asynchronous reset between edges while counting
    do_load(1, 0, "pre_clr_load");
    run(3, "pre_clr");
    #2;
    clr = 1'b1;
    #2;
    model_reset();
    check_outputs("clr_async");
    #2;
    clr = 1'b0;
    run(14, "post_clr");

    // randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      sync = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 19) == 0);
      load_ch = CHW'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) div_in = 8'd255;
      else div_in = N'($urandom_range(0, 12));
      step("random");
    end
    en   = 1'b1;
    sync = 1'b0;
    load = 1'b0;
    run(20, "tail");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
